// File: rtl/game_flow_ctrl_if.sv
// Handshake bundle between the game flow controller and the rest of the game:
// frame/keyboard/collision inputs in, state and control flags out.
interface game_flow_ctrl_if;
  logic       frame_tick;
  logic       start;
  logic       lose_game;
  logic       pellets_empty;
  logic [2:0] state;
  logic       freeze;
  logic       respawn;
  logic [1:0] lives;
  logic       game_over;
  logic       win;

  modport master (
    output frame_tick, start, lose_game, pellets_empty,
    input  state, freeze, respawn, lives, game_over, win
  );

  modport slave (
    input  frame_tick, start, lose_game, pellets_empty,
    output state, freeze, respawn, lives, game_over, win
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// Game sequencing FSM: IDLE -> READY -> PLAY -> DEATH/WIN/GAMEOVER, with lives,
// frame-based timers, collision latching and a one-cycle respawn strobe.
module game_flow_ctrl #(
  parameter int LIVES_INIT   = 3,
  parameter int READY_FRAMES = 120,
  parameter int DEATH_FRAMES = 90
) (
  input  logic          clk,
  input  logic          rst,
  game_flow_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    READY    = 3'd1,
    PLAY     = 3'd2,
    DEATH    = 3'd3,
    GAMEOVER = 3'd4,
    WIN      = 3'd5
  } state_t;

  localparam int CNT_MAX = (READY_FRAMES > DEATH_FRAMES) ? READY_FRAMES : DEATH_FRAMES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] READY_LAST = CNT_W'(READY_FRAMES - 1);
  localparam logic [CNT_W-1:0] DEATH_LAST = CNT_W'(DEATH_FRAMES - 1);
  localparam logic [1:0]       LIVES_LOAD = 2'(LIVES_INIT);

  state_t           state_r, state_nxt;
  logic [1:0]       lives_r, lives_nxt;
  logic [CNT_W-1:0] cnt_r, cnt_nxt;
  logic             hit_r, hit_nxt;
  logic             start_prev_r;
  logic             start_armed_r;
  logic             freeze_r, respawn_r, game_over_r, win_r;
  logic             start_rise_s;
  logic             collide_s;

  // A start held high across reset must be released once before it can start a game.
  assign start_rise_s = bus.start & ~start_prev_r & start_armed_r;
  assign collide_s    = hit_r | bus.lose_game;

  // Collision latch: only meaningful in PLAY, consumed by each frame tick.
  always_comb begin
    hit_nxt = 1'b0;
    if (state_r != PLAY) begin
      hit_nxt = 1'b0;
    end else if (bus.frame_tick) begin
      hit_nxt = 1'b0;
    end else begin
      hit_nxt = hit_r | bus.lose_game;
    end
  end

  // Next-state, lives and frame counter; counter clears on every state change.
  always_comb begin
    state_nxt = state_r;
    lives_nxt = lives_r;
    cnt_nxt   = cnt_r;
    case (state_r)
      IDLE, GAMEOVER, WIN: begin
        if (start_rise_s) begin
          state_nxt = READY;
          lives_nxt = LIVES_LOAD;
        end else begin
          state_nxt = state_r;
        end
      end
      READY: begin
        if (bus.frame_tick && (cnt_r == READY_LAST)) begin
          state_nxt = PLAY;
        end else if (bus.frame_tick) begin
          cnt_nxt = cnt_r + CNT_W'(1);
        end else begin
          cnt_nxt = cnt_r;
        end
      end
      PLAY: begin
        if (bus.frame_tick && collide_s && (lives_r != 2'd0)) begin
          state_nxt = DEATH;
          lives_nxt = lives_r - 2'd1;
        end else if (bus.frame_tick && collide_s) begin
          state_nxt = DEATH;
        end else if (bus.frame_tick && bus.pellets_empty) begin
          state_nxt = WIN;
        end else begin
          state_nxt = PLAY;
        end
      end
      DEATH: begin
        if (bus.frame_tick && (cnt_r == DEATH_LAST)) begin
          state_nxt = (lives_r == 2'd0) ? GAMEOVER : READY;
        end else if (bus.frame_tick) begin
          cnt_nxt = cnt_r + CNT_W'(1);
        end else begin
          cnt_nxt = cnt_r;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (state_nxt != state_r) begin
      cnt_nxt = '0;
    end else begin
      cnt_nxt = cnt_nxt;
    end
  end

  // State registers and registered output decodes of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      lives_r       <= 2'd0;
      cnt_r         <= '0;
      hit_r         <= 1'b0;
      start_prev_r  <= 1'b0;
      start_armed_r <= 1'b0;
      freeze_r      <= 1'b1;
      respawn_r     <= 1'b0;
      game_over_r   <= 1'b0;
      win_r         <= 1'b0;
    end else begin
      state_r       <= state_nxt;
      lives_r       <= lives_nxt;
      cnt_r         <= cnt_nxt;
      hit_r         <= hit_nxt;
      start_prev_r  <= bus.start;
      start_armed_r <= start_armed_r | ~bus.start;
      freeze_r      <= (state_nxt != PLAY);
      respawn_r     <= (state_nxt == READY) && (state_r != READY);
      game_over_r   <= (state_nxt == GAMEOVER);
      win_r         <= (state_nxt == WIN);
    end
  end

  assign bus.state     = state_r;
  assign bus.lives     = lives_r;
  assign bus.freeze    = freeze_r;
  assign bus.respawn   = respawn_r;
  assign bus.game_over = game_over_r;
  assign bus.win       = win_r;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with short timers (READY=4, DEATH=2 frames).
module tb_game_flow_ctrl;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  game_flow_ctrl_if bus();

  game_flow_ctrl #(
    .LIVES_INIT  (3),
    .READY_FRAMES(4),
    .DEATH_FRAMES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] st, input logic [1:0] lv,
                         input logic frz, input logic rsp, input logic go, input logic wn);
    chk({tag, ".state"},     {5'd0, bus.state},     {5'd0, st});
    chk({tag, ".lives"},     {6'd0, bus.lives},     {6'd0, lv});
    chk({tag, ".freeze"},    {7'd0, bus.freeze},    {7'd0, frz});
    chk({tag, ".respawn"},   {7'd0, bus.respawn},   {7'd0, rsp});
    chk({tag, ".game_over"}, {7'd0, bus.game_over}, {7'd0, go});
    chk({tag, ".win"},       {7'd0, bus.win},       {7'd0, wn});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      step();
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus.frame_tick    = 1'b0;
    bus.start         = 1'b0;
    bus.lose_game     = 1'b0;
    bus.pellets_empty = 1'b0;

    // reset values appear before any clock edge
    #1 rst = 1'b1;
    #1;
    chk_all("reset", 3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b0;
    step();
    step();
    chk_all("idle", 3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // start rise -> READY with respawn strobe
    bus.start = 1'b1;
    step();
    chk_all("start", 3'd1, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk("respawn_one_cycle", {7'd0, bus.respawn}, 8'd0);
    bus.start = 1'b0;

    // collisions outside PLAY have no effect
    bus.lose_game = 1'b1;
    step();
    bus.lose_game = 1'b0;
    step();
    chk("lose_in_ready.lives", {6'd0, bus.lives}, 8'd3);

    ticks(3);
    chk("ready_3_ticks", {5'd0, bus.state}, 8'd1);
    tick();
    chk_all("play", 3'd2, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);

    // mid-frame hit with pellets empty: collision wins on the next tick
    bus.pellets_empty = 1'b1;
    bus.lose_game = 1'b1;
    step();
    bus.lose_game = 1'b0;
    step();
    chk("hit_waits_tick", {5'd0, bus.state}, 8'd2);
    tick();
    chk_all("death1", 3'd3, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.pellets_empty = 1'b0;
    tick();
    chk("death_1_tick", {5'd0, bus.state}, 8'd3);
    step();
    tick();
    chk_all("respawn2", 3'd1, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    step();

    // second death: collision on the tick itself
    ticks(4);
    chk("play2", {5'd0, bus.state}, 8'd2);
    bus.lose_game = 1'b1;
    tick();
    bus.lose_game = 1'b0;
    chk_all("death2", 3'd3, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(2);
    chk("ready3", {5'd0, bus.state}, 8'd1);

    // third death ends the game
    ticks(4);
    bus.lose_game = 1'b1;
    tick();
    bus.lose_game = 1'b0;
    chk_all("death3", 3'd3, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    step();
    tick();
    chk_all("gameover", 3'd4, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    chk("gameover_no_respawn", {7'd0, bus.respawn}, 8'd0);

    bus.start = 1'b1;
    step();
    chk_all("restart", 3'd1, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);

    // win with start held high continuously
    ticks(4);
    bus.pellets_empty = 1'b1;
    tick();
    chk_all("win", 3'd5, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    bus.pellets_empty = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("win_held_start", {5'd0, bus.state}, 8'd5);
    bus.start = 1'b0;
    step();
    bus.start = 1'b1;
    step();
    chk_all("win_restart", 3'd1, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);

    // asynchronous reset mid-DEATH, start held through release
    ticks(4);
    bus.lose_game = 1'b1;
    tick();
    bus.lose_game = 1'b0;
    chk("pre_reset_death", {5'd0, bus.state}, 8'd3);
    #2 rst = 1'b1;
    #1;
    chk_all("async_reset", 3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("held_start_ignored", {5'd0, bus.state}, 8'd0);
    bus.start = 1'b0;
    step();
    bus.start = 1'b1;
    step();
    chk_all("fresh_start", 3'd1, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/game_flow_ctrl.md
GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 Parameter LIVES_INIT, default 3, lives loaded on game start (range 1..3).
REQ-002 Parameter READY_FRAMES, default 120, frame ticks spent in READY before play.
REQ-003 Parameter DEATH_FRAMES, default 90, frame ticks spent in DEATH.
REQ-004 Clk  input  1  system clock; all state changes on its rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 frame_tick  input  1  one-Clk pulse per video frame, synchronous to Clk.
REQ-007 start  input  1  level from keyboard start key.
REQ-008 lose_game  input  1  pacman/ghost pixel-overlap flag from entitySelector, may pulse any cycle.
REQ-009 pellets_empty  input  1  level, high when no pellets remain.
REQ-010 state  output  3  current state: IDLE=0, READY=1, PLAY=2, DEATH=3, GAMEOVER=4, WIN=5.
REQ-011 freeze  output  1  high = entity motion logic holds positions.
REQ-012 respawn  output  1  one-Clk pulse; entities return to home positions.
REQ-013 lives  output  2  remaining lives.
REQ-014 game_over  output  1  high while in GAMEOVER.
REQ-015 win  output  1  high while in WIN.

Function
REQ-016 start_rise SHALL be start high this cycle and low the previous cycle (one register); only start_rise starts a game.
REQ-017 hit latch SHALL set on any cycle with lose_game=1 while state=PLAY, and clear on every frame_tick (after being sampled) and in every state other than PLAY.
REQ-018 IDLE: on start_rise -> READY, lives loaded with LIVES_INIT, respawn pulsed.
REQ-019 READY: frame counter cleared on entry, +1 per frame_tick; on the frame_tick where counter=READY_FRAMES-1 -> PLAY (exactly READY_FRAMES ticks).
REQ-020 PLAY: evaluated only on frame_tick; if hit latch (or lose_game that same cycle) set -> DEATH and lives decremented by 1; else if pellets_empty -> WIN; else stay.
REQ-021 Collision SHALL take priority over pellets_empty on the same frame_tick.
REQ-022 DEATH: counter cleared on entry; on the frame_tick where counter=DEATH_FRAMES-1 -> GAMEOVER if lives=0, else READY with respawn pulsed.
REQ-023 GAMEOVER and WIN: on start_rise -> READY, lives reloaded with LIVES_INIT, respawn pulsed.
REQ-024 respawn SHALL be high for exactly the one Clk following each transition into READY; never otherwise.
REQ-025 freeze SHALL be 0 only in PLAY; 1 in all other states.
REQ-026 game_over and win SHALL be registered decodes of state with no extra latency beyond state.
REQ-027 lives SHALL never underflow: decrement occurs only when entering DEATH, and DEATH from lives=0 is impossible since lives=0 ends in GAMEOVER.
REQ-028 start level held high SHALL not retrigger; start_rise outside IDLE/GAMEOVER/WIN is ignored.
REQ-029 frame counter SHALL be wide enough for max(READY_FRAMES, DEATH_FRAMES) and SHALL not wrap within a state.
REQ-030 Undefined state encodings SHALL recover to IDLE on the next Clk.

Reset
REQ-031 Reset=1 SHALL immediately, asynchronously force: state=IDLE, lives=0, freeze=1, respawn=0, game_over=0, win=0, hit latch=0, counter=0, start history=0.
REQ-032 Reset asserted mid-READY/PLAY/DEATH SHALL abandon the game; after release the block waits in IDLE for a fresh start_rise (start held high through release SHALL NOT start).

Verification
REQ-033 Reset release, start 0->1 -> next cycle state=READY, lives=3, respawn=1 for one cycle, freeze=1.
REQ-034 READY_FRAMES=4: 4 frame_ticks -> state=PLAY after 4th tick, freeze=0; 3 ticks -> still READY.
REQ-035 PLAY, lose_game pulse mid-frame with pellets_empty=1 -> on next frame_tick state=DEATH, lives 3->2, win stays 0.
REQ-036 Three deaths from LIVES_INIT=3 -> after third DEATH_FRAMES expire state=GAMEOVER, game_over=1, lives=0, no respawn pulse; start rise -> READY, lives=3.
REQ-037 PLAY, pellets_empty=1, no collision -> on frame_tick state=WIN, win=1; start held high continuously -> stays WIN.
REQ-038 Reset asserted asynchronously mid-DEATH (between Clk edges) -> outputs at reset values before next edge; lose_game pulses in IDLE/READY leave lives unchanged.
